muldiv_iter: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M execute unit in the EX stage, beside the single-cycle ALU.
- Takes funct3 of an R-type instruction with funct7 = 0000001 and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, radix-2.
- Uses a start/busy/done handshake so the hazard unit can stall the pipeline while the unit runs.

---
 rtl/muldiv_iter_pkg.sv | 31 +++
 rtl/muldiv_sign_fix.sv | 18 +
 rtl/muldiv_iter.sv | 218 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative RV32M/RV64M multiply/divide unit:
// M-extension funct3/funct7 codes, FSM state codes, instruction field macros.

`ifndef MULDIV_ITER_FIELD_MACROS
`define MULDIV_ITER_FIELD_MACROS
`define OPCODE(instr) instr[6:0]
`define FUNCT3(instr) instr[14:12]
`define FUNCT7(instr) instr[31:25]
`endif

package muldiv_iter_pkg;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_PREP = 2'd1;
    localparam state_t S_CALC = 2'd2;
    localparam state_t S_FIX  = 2'd3;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of the final result.

module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    // Negate when requested, otherwise pass through unchanged.
    always_comb begin
        y = x;
        if (neg) y = ~x + W'(1);
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit for the EX stage (start/busy/done).
// Optional macro MULDIV_EARLY_OUT_EN lets trivial operations skip CALC.

module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    logic [2:0]        op;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              res_neg;
    logic              div0;
    logic              ovf;

    logic              is_div;
    logic              is_rem;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic              ovf_hit;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;

    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] acc_mul;
    logic [XLEN:0]     partial;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   rem_n;
    logic [2*XLEN-1:0] acc_div;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   div_fix;
    logic [XLEN-1:0]   result;

    // Operand classification and one radix-2 step for both directions.
    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        a_signed = (op == F3_MULH) | (op == F3_MULHSU)
                 | (op == F3_DIV)  | (op == F3_REM);
        b_signed = (op == F3_MULH) | (op == F3_DIV) | (op == F3_REM);
        a_neg    = a_signed & a_raw[XLEN-1];
        b_neg    = b_signed & b_reg[XLEN-1];
        b_zero   = (b_reg == '0);
        ovf_hit  = ((op == F3_DIV) | (op == F3_REM))
                 & (a_raw == MOST_NEG) & (b_reg == ALL_ONES);

        // Shift-add: multiplier bits leave a_reg LSB-first.
        addend  = a_reg[0] ? b_reg : '0;
        msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        acc_mul = {msum, acc[XLEN-1:1]};

        // Restoring divide: remainder high, quotient shifts in low.
        partial = {acc[2*XLEN-1:XLEN], a_reg[XLEN-1]};
        ge      = partial[XLEN] | (partial[XLEN-1:0] >= b_reg);
        diff    = partial[XLEN-1:0] - b_reg;
        rem_n   = ge ? diff : partial[XLEN-1:0];
        acc_div = {rem_n, acc[XLEN-2:0], ge};

        div_sel = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    end

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (
        .neg (a_neg),
        .x   (a_raw),
        .y   (a_abs)
    );

    muldiv_sign_fix #(.W(XLEN)) u_abs_b (
        .neg (b_neg),
        .x   (b_reg),
        .y   (b_abs)
    );

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .neg (res_neg),
        .x   (acc),
        .y   (prod_fix)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_div (
        .neg (res_neg),
        .x   (div_sel),
        .y   (div_fix)
    );

    // Final result select, with the RISC-V divide corner cases.
    always_comb begin
        result = '0;
        unique case (1'b1)
            is_div & div0 & ~op[1]:  result = ALL_ONES;
            is_div & div0 & op[1]:   result = a_raw;
            is_div & ovf & ~op[1]:   result = a_raw;
            is_div & ovf & op[1]:    result = '0;
            is_div & ~div0 & ~ovf:   result = div_fix;
            ~is_div & (op[1:0] == 2'b00):
                result = prod_fix[XLEN-1:0];
            default:
                result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic early;
    assign early = is_div ? (b_zero | ovf_hit)
                          : ((a_raw == '0) | b_zero);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a flush returns any active operation to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (i_start && !i_flush) state_nxt = S_PREP;
`ifdef MULDIV_EARLY_OUT_EN
            S_PREP: state_nxt = early ? S_FIX : S_CALC;
`else
            S_PREP: state_nxt = S_CALC;
`endif
            S_CALC: if (cnt == CNT_ONE) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Busy whenever an operation is in flight.
    always_comb begin
        o_busy = (state != S_IDLE);
    end

    // Datapath registers: capture, prepare, iterate, publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= '0;
            a_raw    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            res_neg  <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        op    <= i_funct3;
                        a_raw <= i_a;
                        b_reg <= i_b;
                        div0  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                S_PREP: begin
                    a_reg   <= a_abs;
                    b_reg   <= b_abs;
                    res_neg <= a_neg ^ (b_neg & ~is_rem);
                    div0    <= is_div & b_zero;
                    ovf     <= ovf_hit;
                    acc     <= '0;
                    cnt     <= CNT_INIT;
                end
                S_CALC: begin
                    acc   <= is_div ? acc_div : acc_mul;
                    a_reg <= is_div ? (a_reg << 1) : (a_reg >> 1);
                    cnt   <= cnt - CNT_ONE;
                end
                S_FIX: begin
                    if (!i_flush) begin
                        o_result <= result;
                        o_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal results.

module tb_muldiv_iter;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    localparam int LAT = 34;
    localparam int LS  = EO ? 2 : 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    logic        start64 = 1'b0;
    logic [2:0]  f3_64 = '0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        busy64;
    logic        done64;
    logic [63:0] res64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    muldiv_iter dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_flush  (flush),
        .i_funct3 (f3),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (res)
    );

    muldiv_iter #(.XLEN(64)) dut64 (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start64),
        .i_flush  (1'b0),
        .i_funct3 (f3_64),
        .i_a      (a64),
        .i_b      (b64),
        .o_busy   (busy64),
        .o_done   (done64),
        .o_result (res64)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference arithmetic straight from the RISC-V M definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] fn,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (fn)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = sx / sy; return p[31:0];
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] fn,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
        bit early;
        if (fn[2])
            early = (y == 0) || ((fn == 3'b100 || fn == 3'b110)
                    && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        else
            early = (x == 0) || (y == 0);
        return (EO && early) ? 2 : LAT;
    endfunction

    // Transaction-level model of the 32-bit unit.
    bit          m_pend = 1'b0;
    bit          m_fire = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_hold = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_fire = 1'b0;
            m_hold = '0;
        end else begin
            cyc++;
            m_fire = 1'b0;
            if (m_pend) begin
                if (flush) begin
                    m_pend = 1'b0;
                end else if (cyc == m_done_at) begin
                    m_pend = 1'b0;
                    m_fire = 1'b1;
                    m_hold = m_res;
                end
            end else if (start && !flush) begin
                m_pend    = 1'b1;
                m_done_at = cyc + lat_of(f3, a, b);
                m_res     = ref_op(f3, a, b);
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_pend));
        check("done", 64'(done), 64'(m_fire));
        check("result", 64'(res), 64'(m_hold));
    end

    task automatic do_op(input string name, input logic [2:0] fn,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int exp_lat);
        int t0;
        bit seen;
        check({name, " model"}, 64'(ref_op(fn, x, y)), 64'(exp));
        start = 1'b1; f3 = fn; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin seen = 1'b1; break; end
            start = (k == 3 && exp_lat > 4);
            if (start) begin f3 = 3'b011; a = ~x; end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " timeout"}, 64'(seen), 64'(1));
        check({name, " value"}, 64'(res), 64'(exp));
        check({name, " latency"}, 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic do_op64(input string name, input logic [2:0] fn,
                           input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] exp);
        int t0;
        bit seen;
        start64 = 1'b1; f3_64 = fn; a64 = x; b64 = y;
        @(negedge clk);
        start64 = 1'b0;
        t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done64) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({name, " timeout"}, 64'(seen), 64'(1));
        check({name, " value"}, res64, exp);
        check({name, " latency"}, 64'(cyc - t0), 64'(66));
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(res), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        do_op("mul",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        do_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
        do_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        do_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
        do_op("mulh neg", 3'b001, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, LAT);
        do_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT);
        do_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT);
        do_op("divu",     3'b101, 32'd100,       32'd7,         32'd14,        LAT);
        do_op("remu",     3'b111, 32'd100,       32'd7,         32'd2,         LAT);
        do_op("rem negb", 3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         LAT);
        do_op("div0",     3'b100, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, LS);
        do_op("rem0",     3'b110, 32'd5,         32'd0,         32'd5,         LS);
        do_op("divu0",    3'b101, 32'h0000_0042, 32'd0,         32'hFFFF_FFFF, LS);
        do_op("remu0",    3'b111, 32'h0000_ABCD, 32'd0,         32'h0000_ABCD, LS);
        do_op("div ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LS);
        do_op("rem ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LS);
        do_op("mul0",     3'b000, 32'd0,         32'd12345,     32'd0,         LS);
        do_op("div negb", 3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);

        // Flush mid-divide, then restart right away.
        start = 1'b1; f3 = 3'b101; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        check("flush done", 64'(done), 64'(0));
        check("flush hold", 64'(res), 64'(32'hFFFF_FFFD));
        start = 1'b1; f3 = 3'b111; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("restart accept", 64'(cyc - t0), 64'(11));
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check("restart value", 64'(res), 64'(2));
        check("restart edge", 64'(cyc - t0), 64'(45));

        // Asynchronous reset in the middle of CALC.
        start = 1'b1; f3 = 3'b000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'(0));
        check("async rst done", 64'(done), 64'(0));
        check("async rst result", 64'(res), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("after rst", 3'b101, 32'd1000, 32'd10, 32'd100, LAT);

        do_op64("mul64",   3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0);
        do_op64("mulhu64", 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
